// File: rtl/axis_frame_packer.sv
// axis_frame_packer: packs a raw AXI-Stream byte stream into framed packets
//   SOF, seq, 1..MAX_LEN payload bytes, [xor], length trailer (tlast).
// A frame closes on MAX_LEN payload bytes or after TIMEOUT idle input cycles.
// Optional feature macro: AXIS_FRAME_PACKER_XOR_EN adds a running-XOR check
// byte between the payload and the length trailer.
module axis_frame_packer #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [7:0]  SOF     = 8'hBC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] frame_count,
  output logic        timeout_flush,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    SEQ,
    PAYLOAD,
`ifdef AXIS_FRAME_PACKER_XOR_EN
    CHK,
`endif
    TRAILER
  } state_t;

  localparam logic [7:0]  LEN_MAX  = 8'(MAX_LEN);
  localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT);

`ifdef AXIS_FRAME_PACKER_XOR_EN
  localparam state_t CLOSE_ST = CHK;
`else
  localparam state_t CLOSE_ST = TRAILER;
`endif

  state_t      state_q, state_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] idle_q, idle_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        flush_q, flush_d;
`ifdef AXIS_FRAME_PACKER_XOR_EN
  logic [7:0]  xor_q, xor_d;
`endif

  logic out_free;
  logic closing;
  logic take;

  // Next-state, output-register load and input-ready decode.
  always_comb begin
    out_free      = !tvalid_q || m_axis_tready;
    // Closing is decided from registered state only, so ready never waits on
    // s_axis_tvalid and no byte can slip in on the timeout edge.
    closing       = (state_q == PAYLOAD) && (idle_q == IDLE_MAX);
    s_axis_tready = (state_q == PAYLOAD) && out_free && !closing;
    take          = s_axis_tready && s_axis_tvalid;

    state_d  = state_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = out_free ? 1'b0 : tvalid_q;
    fcnt_d   = fcnt_q;
    flush_d  = 1'b0;
`ifdef AXIS_FRAME_PACKER_XOR_EN
    xor_d    = xor_q;
`endif

    case (state_q)
      IDLE: begin
        if (s_axis_tvalid && out_free) begin
          tdata_d  = SOF;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          state_d  = SEQ;
        end
      end
      SEQ: begin
        if (out_free) begin
          tdata_d  = seq_q;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          cnt_d    = 8'd0;
          idle_d   = 16'd0;
`ifdef AXIS_FRAME_PACKER_XOR_EN
          xor_d    = 8'd0;
`endif
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (take) begin
          tdata_d  = s_axis_tdata;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          cnt_d    = cnt_q + 8'd1;
          idle_d   = 16'd0;
`ifdef AXIS_FRAME_PACKER_XOR_EN
          xor_d    = xor_q ^ s_axis_tdata;
`endif
          if (cnt_q + 8'd1 == LEN_MAX) begin
            state_d = CLOSE_ST;
          end
        end else if (closing) begin
          flush_d = 1'b1;
          state_d = CLOSE_ST;
        end else if (!s_axis_tvalid && (cnt_q != 8'd0)) begin
          // Stalls caused by output backpressure keep tvalid high and are not idle.
          idle_d = idle_q + 16'd1;
        end
      end
`ifdef AXIS_FRAME_PACKER_XOR_EN
      CHK: begin
        if (out_free) begin
          tdata_d  = xor_q;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          state_d  = TRAILER;
        end
      end
`endif
      TRAILER: begin
        if (out_free) begin
          tdata_d  = cnt_q;
          tlast_d  = 1'b1;
          tvalid_d = 1'b1;
          seq_d    = seq_q + 8'd1;
          fcnt_d   = fcnt_q + 16'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output register; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      seq_q    <= 8'd0;
      cnt_q    <= 8'd0;
      idle_q   <= 16'd0;
      tdata_q  <= 8'd0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      fcnt_q   <= 16'd0;
      flush_q  <= 1'b0;
`ifdef AXIS_FRAME_PACKER_XOR_EN
      xor_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      fcnt_q   <= fcnt_d;
      flush_q  <= flush_d;
`ifdef AXIS_FRAME_PACKER_XOR_EN
      xor_q    <= xor_d;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_count   = fcnt_q;
  assign timeout_flush = flush_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_axis_frame_packer.sv
// Testbench for axis_frame_packer: table of streams driven through a
// transaction-level scoreboard, plus wrap-around and mid-frame reset sequences.
module tb_axis_frame_packer;
  localparam int MAX_LEN = 32;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_tdata = 8'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [15:0] frame_count;
  logic        timeout_flush;
  logic        busy;

  always #5 clk = ~clk;

  axis_frame_packer #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .SOF(8'hBC)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .frame_count(frame_count),
    .timeout_flush(timeout_flush), .busy(busy)
  );

  typedef struct packed { logic [7:0] data; logic last; } exp_t;
  typedef struct {
    int         n;
    logic [7:0] first;
    logic [7:0] step;
    bit         shl;
    bit         bp;
    int         frames;
    int         flushes;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] stim_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state (frame level)
  bit         in_frame = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_seq = 8'd0;
  logic [7:0] m_xor = 8'd0;
  int         flush_seen = 0;
  bit         accepted = 1'b0;
  bit         bp_mode = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic       prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push(input logic [7:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endfunction

  function automatic void close_frame();
`ifdef AXIS_FRAME_PACKER_XOR_EN
    push(m_xor, 1'b0);
`endif
    push(8'(m_cnt), 1'b1);
    m_seq    = m_seq + 8'd1;
    in_frame = 1'b0;
  endfunction

  // One clock: checks at the falling edge, returns 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    m_tready = bp_mode ? ~m_tready : 1'b1;
    @(negedge clk);
    if (prev_stall) begin
      check("stall_valid", 32'(m_tvalid), 32'd1);
      check("stall_data", 32'(m_tdata), 32'(prev_data));
      check("stall_last", 32'(m_tlast), 32'(prev_last));
    end
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: actual=%0h last=%0b required=none", m_tdata, m_tlast);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(m_tdata), 32'(e.data));
        check("out_last", 32'(m_tlast), 32'(e.last));
      end
    end
    if (timeout_flush) flush_seen++;
    accepted = 1'b0;
    if (s_tvalid && s_tready) begin
      accepted = 1'b1;
      push(s_tdata, 1'b0);
      m_cnt++;
      m_xor = m_xor ^ s_tdata;
      if (m_cnt == MAX_LEN) close_frame();
    end else if (s_tvalid && !in_frame) begin
      in_frame = 1'b1;
      m_cnt    = 0;
      m_xor    = 8'd0;
      push(8'hBC, 1'b0);
      push(m_seq, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      tick();
      g++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual=%0d bytes outstanding required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (TIMEOUT + 4) tick();
  endtask

  task automatic run_stream();
    int i = 0;
    int guard = 0;
    while (i < stim_q.size() && guard < 20000) begin
      s_tvalid = 1'b1;
      s_tdata  = stim_q[i];
      tick();
      if (accepted) i++;
      guard++;
    end
    if (i < stim_q.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL stream_stall: actual=%0d accepted required=%0d", i, stim_q.size());
    end
    s_tvalid = 1'b0;
    s_tdata  = 8'd0;
    // whatever is left open must be closed by the idle timeout
    if (in_frame && m_cnt > 0) close_frame();
    drain();
  endtask

  // Asserts reset between clock edges and checks the outputs react immediately.
  task automatic do_reset();
    s_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_sready", 32'(s_tready), 32'd0);
    check("rst_fcount", 32'(frame_count), 32'd0);
    check("rst_flush", 32'(timeout_flush), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    in_frame   = 1'b0;
    m_cnt      = 0;
    m_seq      = 8'd0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic [15:0] fc0;
    int          fs0;

    vecs[0] = '{3,  8'h11, 8'h11, 1'b0, 1'b0, 1, 1};  // BC 00 11 22 33 03
    vecs[1] = '{64, 8'h00, 8'h01, 1'b0, 1'b0, 2, 0};  // two full frames
    vecs[2] = '{70, 8'h40, 8'h01, 1'b0, 1'b1, 3, 1};  // 32,32,6 under backpressure
    vecs[3] = '{33, 8'hA0, 8'h03, 1'b0, 1'b0, 2, 1};  // full frame plus one byte
    vecs[4] = '{3,  8'h01, 8'h00, 1'b1, 1'b0, 1, 1};  // 01 02 04
    vecs[5] = '{1,  8'h5A, 8'h00, 1'b0, 1'b1, 1, 1};  // minimum frame, stalled

    #2;
    do_reset();

    for (int v = 0; v < 6; v++) begin
      fc0 = frame_count;
      fs0 = flush_seen;
      bp_mode = vecs[v].bp;
      stim_q.delete();
      for (int j = 0; j < vecs[v].n; j++) begin
        if (vecs[v].shl) stim_q.push_back(vecs[v].first << j);
        else             stim_q.push_back(vecs[v].first + 8'(j) * vecs[v].step);
      end
      run_stream();
      check("vec_frames", 32'(16'(frame_count - fc0)), 32'(vecs[v].frames));
      check("vec_flushes", 32'(flush_seen - fs0), 32'(vecs[v].flushes));
      check("vec_idle_busy", 32'(busy), 32'd0);
    end

    // sequence wrap: 257 single-byte frames
    bp_mode = 1'b0;
    do_reset();
    fs0 = flush_seen;
    for (int k = 0; k < 257; k++) begin
      stim_q.delete();
      stim_q.push_back(8'(k));
      run_stream();
    end
    check("wrap_fcount", 32'(frame_count), 32'd257);
    check("wrap_flushes", 32'(flush_seen - fs0), 32'd257);

    // asynchronous reset after five payload bytes, then a clean frame
    do_reset();
    begin
      int got = 0;
      int guard = 0;
      while (got < 5 && guard < 100) begin
        s_tvalid = 1'b1;
        s_tdata  = 8'hC0 + 8'(got);
        tick();
        if (accepted) got++;
        guard++;
      end
      check("pre_rst_bytes", 32'(got), 32'd5);
    end
    #2;
    do_reset();
    fc0 = frame_count;
    stim_q.delete();
    stim_q.push_back(8'h77);
    stim_q.push_back(8'h88);
    run_stream();
    check("post_rst_frames", 32'(16'(frame_count - fc0)), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
